// File: rtl/iq_phase_pkg.sv
// Shared types and arctangent table for the IQ phase detector.
// Table entries are atan(2^-i) expressed in 32-bit turns.
package iq_phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREROT = 2'd1,
        ST_ITER   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [31:0] ATAN_TURNS [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // Round entry idx to pw bits (pw < 32); result is right-aligned.
    function automatic logic [31:0] atan_entry(input int idx, input int pw);
        logic [32:0] sum;
        sum = {1'b0, ATAN_TURNS[idx]} + (33'd1 << (31 - pw));
        return 32'(sum >> (32 - pw));
    endfunction

endpackage

// File: rtl/cordic_vector_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y towards zero
// and accumulates the applied rotation into z.
module cordic_vector_step #(
    parameter int DW = 40,
    parameter int ZW = 16,
    parameter int SW = 4
) (
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic        [ZW-1:0] z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic        [ZW-1:0] atan_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic        [ZW-1:0] z_o
);

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;

    // Rotation direction follows the sign of y; both updates use pre-step x, y.
    always_comb begin
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        if (!y_i[DW-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/iq_phase_detector.sv
// Iterative CORDIC phase/magnitude detector with decimated capture and a
// registered phase-step output for the downstream control loop.
module iq_phase_detector
    import iq_phase_pkg::*;
#(
    parameter int IN_WIDTH      = 38,
    parameter int PHASE_WIDTH   = 16,
    parameter int ITERATIONS    = 16,
    parameter int SAMPLE_PERIOD = 40
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CE,
    input  logic signed [IN_WIDTH-1:0]    SIN_MUL_ACC,
    input  logic signed [IN_WIDTH-1:0]    COS_MUL_ACC,
    output logic        [PHASE_WIDTH-1:0] PHASE,
    output logic        [IN_WIDTH+1:0]    MAGNITUDE,
    output logic signed [PHASE_WIDTH-1:0] PHASE_DELTA,
    output logic                          PHASE_VALID
);

    localparam int XW = IN_WIDTH + 2;
    localparam int PW = PHASE_WIDTH;
    localparam int IW = $clog2(ITERATIONS);
    localparam int CW = $clog2(SAMPLE_PERIOD);

    if ((SAMPLE_PERIOD < ITERATIONS + 3) || (ITERATIONS < 8) || (ITERATIONS > PHASE_WIDTH)) begin : g_bad_params
        $error("iq_phase_detector: need 8 <= ITERATIONS <= PHASE_WIDTH and SAMPLE_PERIOD >= ITERATIONS+3");
    end

    logic [PW-1:0] atan_tab [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam logic [31:0] ENTRY = atan_entry(g, PHASE_WIDTH);
        assign atan_tab[g] = ENTRY[PW-1:0];
    end

    state_e               state_q, state_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic        [IW-1:0] iter_q, iter_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic        [PW-1:0] z_q, z_d;
    logic                 zero_q, zero_d;
    logic        [PW-1:0] phase_q, phase_d;
    logic        [XW-1:0] mag_q, mag_d;
    logic signed [PW-1:0] delta_q, delta_d;
    logic                 valid_q, valid_d;

    logic signed [XW-1:0] x_nx, y_nx;
    logic        [PW-1:0] z_nx;

    cordic_vector_step #(
        .DW(XW),
        .ZW(PW),
        .SW(IW)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .shift_i(iter_q),
        .atan_i (atan_tab[iter_q]),
        .x_o    (x_nx),
        .y_o    (y_nx),
        .z_o    (z_nx)
    );

    // Next-state logic: everything holds unless CE, and the valid pulse never outlives one enabled DONE step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        phase_d = phase_q;
        mag_d   = mag_q;
        delta_d = delta_q;
        valid_d = 1'b0;
        if (CE) begin
            if (cnt_q == CW'(SAMPLE_PERIOD - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == '0) begin
                        x_d     = XW'(SIN_MUL_ACC);
                        y_d     = XW'(COS_MUL_ACC);
                        state_d = ST_PREROT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREROT: begin
                    // Fold the left half-plane onto the right so the CORDIC range suffices.
                    if (x_q[XW-1]) begin
                        x_d = -x_q;
                        y_d = -y_q;
                        z_d = {1'b1, {(PW-1){1'b0}}};
                    end else begin
                        z_d = '0;
                    end
                    zero_d  = (x_q == '0) && (y_q == '0);
                    iter_d  = '0;
                    state_d = ST_ITER;
                end
                ST_ITER: begin
                    x_d = x_nx;
                    y_d = y_nx;
                    z_d = z_nx;
                    if (iter_q == IW'(ITERATIONS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        iter_d = iter_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (zero_q) begin
                        phase_d = '0;
                        mag_d   = '0;
                    end else begin
                        phase_d = z_q;
                        mag_d   = $unsigned(x_q);
                    end
                    delta_d = $signed(phase_d - phase_q);
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            phase_q <= '0;
            mag_q   <= '0;
            delta_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            phase_q <= phase_d;
            mag_q   <= mag_d;
            delta_q <= delta_d;
            valid_q <= valid_d;
        end
    end

    assign PHASE       = phase_q;
    assign MAGNITUDE   = mag_q;
    assign PHASE_DELTA = delta_q;
    assign PHASE_VALID = valid_q;

endmodule

// File: tb/tb_iq_phase_detector.sv
// Bench for iq_phase_detector: ideal atan2/hypot reference with CORDIC
// quantisation tolerances, compared every cycle against the DUT outputs.
module tb_iq_phase_detector;

    localparam int  IN_WIDTH      = 38;
    localparam int  PHASE_WIDTH   = 16;
    localparam int  ITERATIONS    = 16;
    localparam int  SAMPLE_PERIOD = 40;
    localparam int  LATENCY       = ITERATIONS + 2;
    localparam real TWO_PI        = 6.283185307179586;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic                   CE;
    logic signed [37:0]     SIN_MUL_ACC;
    logic signed [37:0]     COS_MUL_ACC;
    logic        [15:0]     PHASE;
    logic        [39:0]     MAGNITUDE;
    logic signed [15:0]     PHASE_DELTA;
    logic                   PHASE_VALID;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    iq_phase_detector #(
        .IN_WIDTH     (IN_WIDTH),
        .PHASE_WIDTH  (PHASE_WIDTH),
        .ITERATIONS   (ITERATIONS),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CE         (CE),
        .SIN_MUL_ACC(SIN_MUL_ACC),
        .COS_MUL_ACC(COS_MUL_ACC),
        .PHASE      (PHASE),
        .MAGNITUDE  (MAGNITUDE),
        .PHASE_DELTA(PHASE_DELTA),
        .PHASE_VALID(PHASE_VALID)
    );

    typedef struct {
        longint s;
        longint c;
        int     due;
    } cap_t;

    real  cordic_gain = 1.0;
    cap_t pend[$];
    int   en_cnt    = 0;
    int   exp_valid = 0;
    int   exp_phase = 0;
    int   tol_phase = 0;
    int   exp_delta = 0;
    int   tol_delta = 0;
    real  exp_mag   = 0.0;
    real  tol_mag   = 0.0;

    function automatic int ideal_phase(input longint s, input longint c);
        real t;
        int  p;
        t = $atan2(real'(c), real'(s)) / TWO_PI;
        if (t < 0.0) t = t + 1.0;
        p = $rtoi(t * 65536.0 + 0.5);
        return p % 65536;
    endfunction

    function automatic real ideal_mag(input longint s, input longint c);
        return $sqrt(real'(s) * real'(s) + real'(c) * real'(c)) * cordic_gain;
    endfunction

    function automatic int wrap_dist(input int a, input int b);
        int d;
        d = (a - b) & 32'hFFFF;
        if (d >= 32768) d = 65536 - d;
        return d;
    endfunction

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (wrap_dist(act, exp) > tol) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h +/-%0d at %0t", name, act[15:0], exp[15:0], tol, $time);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_mag(input real act, input real exp, input real tol);
        checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            errors++;
            $display("FAIL magnitude: got %0.1f expected %0.1f +/-%0.1f at %0t", act, exp, tol, $time);
        end
    endtask

    // New reference result: ideal angle and length, tolerance widening for short vectors.
    task automatic model_result(input longint s, input longint c);
        int  np;
        int  nt;
        real r;
        if (s == 0 && c == 0) begin
            np      = 0;
            nt      = 0;
            exp_mag = 0.0;
            tol_mag = 0.0;
        end else begin
            np = ideal_phase(s, c);
            r  = ideal_mag(s, c);
            nt = 6 + $rtoi(3.0 * 65536.0 / (TWO_PI * r));
            if (nt > 16384) nt = 16384;
            exp_mag = r;
            tol_mag = 40.0 + r * 1.0e-6;
        end
        exp_delta = (np - exp_phase) & 32'hFFFF;
        tol_delta = nt + tol_phase;
        exp_phase = np;
        tol_phase = nt;
        exp_valid = 1;
    endtask

    // Reference model steps on every edge, outputs are compared on the following falling edge.
    initial begin
        cap_t cp;
        forever begin
            @(posedge CLK);
            if (RESET) begin
                en_cnt = 0;
                pend.delete();
                exp_valid = 0;
                exp_phase = 0;
                tol_phase = 0;
                exp_delta = 0;
                tol_delta = 0;
                exp_mag   = 0.0;
                tol_mag   = 0.0;
            end else if (CE) begin
                exp_valid = 0;
                if (en_cnt % SAMPLE_PERIOD == 0) begin
                    cp.s   = longint'(SIN_MUL_ACC);
                    cp.c   = longint'(COS_MUL_ACC);
                    cp.due = en_cnt + LATENCY;
                    pend.push_back(cp);
                end
                if (pend.size() > 0 && pend[0].due == en_cnt) begin
                    cp = pend.pop_front();
                    model_result(cp.s, cp.c);
                end
                en_cnt++;
            end else begin
                exp_valid = 0;
            end
            @(negedge CLK);
            check_eq("valid", int'(PHASE_VALID), exp_valid);
            check_near("phase", int'(PHASE), exp_phase, tol_phase);
            check_near("delta", int'(PHASE_DELTA), exp_delta, tol_delta);
            check_mag(real'(MAGNITUDE), exp_mag, tol_mag);
        end
    end

    // One capture period of SAMPLE_PERIOD enabled edges, starting on a capture edge.
    task automatic run_period(input string name, input longint s, input longint c, input bit toggle);
        int en;
        int e;
        int lat;
        int pulses;
        SIN_MUL_ACC = s[37:0];
        COS_MUL_ACC = c[37:0];
        en     = 0;
        e      = 0;
        lat    = -1;
        pulses = 0;
        while (en < SAMPLE_PERIOD) begin
            CE = toggle ? (e % 2 == 0) : 1'b1;
            @(posedge CLK);
            if (CE) en++;
            @(negedge CLK);
            if (PHASE_VALID) begin
                pulses++;
                if (lat < 0) lat = e;
            end
            e++;
        end
        check_eq({name, " pulses"}, pulses, 1);
        check_eq({name, " latency"}, lat, toggle ? 2 * LATENCY : LATENCY);
    endtask

    function automatic longint rand38();
        logic signed [37:0] v;
        v = 38'({$urandom(), $urandom()});
        v = v >>> $urandom_range(0, 20);
        return longint'(v);
    endfunction

    initial begin
        real    p;
        real    a;
        longint big;
        RESET       = 1'b1;
        CE          = 1'b0;
        SIN_MUL_ACC = '0;
        COS_MUL_ACC = '0;
        p = 1.0;
        for (int i = 0; i < ITERATIONS; i++) begin
            cordic_gain = cordic_gain * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        big = -(longint'(1) << 37);
        a   = 68719476736.0;

        check_eq("pin model 0deg", ideal_phase(1000, 0), 0);
        check_eq("pin model 90deg", ideal_phase(0, 1000), 16384);
        check_eq("pin model 180deg", ideal_phase(-1000, 0), 32768);
        check_eq("pin model 270deg", ideal_phase(0, -1000), 49152);
        check_eq("pin model 225deg", ideal_phase(big, big), 40960);
        check_eq("pin model mag", $rtoi(ideal_mag(1000, 0) + 0.5), 1647);

        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        run_period("x1000", 1000, 0, 1'b0);
        check_near("x1000 phase", int'(PHASE), 0, 24);
        check_mag(real'(MAGNITUDE), 1647.0, 8.0);
        run_period("y1000", 0, 1000, 1'b0);
        run_period("xneg1000", -1000, 0, 1'b0);
        check_near("xneg1000 delta", int'(PHASE_DELTA), 16'h4000, 48);
        run_period("x1000b", 1000, 0, 1'b0);
        run_period("yneg1000", 0, -1000, 1'b0);
        check_near("yneg1000 delta", int'(PHASE_DELTA), 16'hC000, 48);
        run_period("ang_f000", longint'(a * $cos(-TWO_PI / 16.0)), longint'(a * $sin(-TWO_PI / 16.0)), 1'b0);
        run_period("ang_1000", longint'(a * $cos(TWO_PI / 16.0)), longint'(a * $sin(TWO_PI / 16.0)), 1'b0);
        check_near("wrap delta", int'(PHASE_DELTA), 16'h2000, 16);
        run_period("full_neg", big, big, 1'b0);
        check_near("full_neg phase", int'(PHASE), 16'hA000, 6);
        run_period("zero", 0, 0, 1'b0);
        check_eq("zero magnitude", int'(MAGNITUDE == 40'd0), 1);
        run_period("min_x", big, 0, 1'b0);
        run_period("ce_half_y", 0, 1000, 1'b1);
        run_period("ce_half_rand", rand38(), rand38(), 1'b1);

        for (int k = 0; k < 16; k++) begin
            run_period("rand", rand38(), rand38(), 1'($urandom_range(0, 1)));
        end

        SIN_MUL_ACC = 38'sd123456789;
        COS_MUL_ACC = -38'sd987654321;
        CE          = 1'b1;
        repeat (7) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_eq("mid reset phase", int'(PHASE), 0);
        check_eq("mid reset valid", int'(PHASE_VALID), 0);
        run_period("after_reset", 123456789, -987654321, 1'b0);
        run_period("after_reset2", rand38(), rand38(), 1'b0);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iq_phase_detector.md
# iq_phase_detector

Converts the filtered quadrature products of `adc_dac_frontend` (SIN_MUL_ACC, COS_MUL_ACC) into phase angle, magnitude and phase-step-per-update, at a fixed decimated rate. Sits directly downstream of the frontend and feeds the phase-increment control loop and the host readout. Uses an iterative CORDIC in vectoring mode, one micro-rotation per enabled cycle.

## Interface
- IN_WIDTH, 38: width of signed SIN/COS inputs; matches RESULT_MUL_ACC_WIDTH.
- PHASE_WIDTH, 16: phase output width; full scale is one turn, unsigned.
- ITERATIONS, 16: CORDIC micro-rotations, range 8..PHASE_WIDTH.
- SAMPLE_PERIOD, 40: enabled cycles between input captures; must be ≥ ITERATIONS+3.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high.
- CE  in  1  clock enable; all state advances only when CE=1.
- SIN_MUL_ACC  in  IN_WIDTH  signed in-phase accumulator (x).
- COS_MUL_ACC  in  IN_WIDTH  signed quadrature accumulator (y).
- PHASE  out  PHASE_WIDTH  atan2(COS,SIN)/2π in turns, wraps modulo 2^PHASE_WIDTH.
- MAGNITUDE  out  IN_WIDTH+2  unsigned, sqrt(x²+y²)·K, K≈1.6468, uncompensated.
- PHASE_DELTA  out  PHASE_WIDTH  signed, PHASE minus previous PHASE, modulo wrap.
- PHASE_VALID  out  1  one-cycle pulse when outputs update.

## Operation
- Sample counter counts 0..SAMPLE_PERIOD-1 on CE; capture at count 0 (first CE after reset captures immediately).
- FSM states: IDLE → PREROT → ITER → DONE → IDLE.
- IDLE: on capture, latch inputs sign-extended to IN_WIDTH+2 bits as x, y; go PREROT.
- PREROT: if x<0: x←-x, y←-y, z←2^(PHASE_WIDTH-1); else z←0. If captured x=0 and y=0 set zero flag. Go ITER, i=0.
- ITER, step i: if y≥0 {x←x+(y>>>i); y←y-(x>>>i); z←z+ATAN[i]} else {x←x-(y>>>i); y←y+(x>>>i); z←z-ATAN[i]}; all updates use pre-step x,y. After i=ITERATIONS-1 go DONE.
- DONE: PHASE←zero flag ? 0 : z; MAGNITUDE←zero flag ? 0 : x (x≥0 guaranteed); PHASE_DELTA←new PHASE − old PHASE (wrapping subtraction, reinterpreted signed); pulse PHASE_VALID; go IDLE.
- First result after reset: PHASE_DELTA computed against reset PHASE 0.
- Capture while not IDLE cannot occur by parameter constraint; elaboration-time assertion enforces SAMPLE_PERIOD ≥ ITERATIONS+3.
- Width rule: IN_WIDTH+2 internal x/y covers negation of -2^(IN_WIDTH-1), √2 vector length and gain K; no saturation needed.

## Timing
- Reset: PHASE=0, MAGNITUDE=0, PHASE_DELTA=0, PHASE_VALID=0, counter=0, FSM=IDLE, z/x/y cleared.
- Latency: inputs sampled at capture edge; PHASE_VALID asserted ITERATIONS+2 enabled cycles later.
- Outputs hold between pulses.
- CE=0: FSM, counter and datapath freeze; PHASE_VALID forced 0 during CE=0 and does not repeat on resumption.
- RESET mid-iteration: result discarded, no PHASE_VALID, restart from reset state next cycle.
- Angular accuracy: ±(ITERATIONS-dependent) ≤ 2 LSB at PHASE_WIDTH=16, ITERATIONS=16.

## Structure
- Shared package iq_phase_pkg: ATAN table constant, 32-bit turns values round(2^32·atan(2^-i)/2π), i=0..31, truncated with rounding to PHASE_WIDTH by a package function; FSM state enum.
- One sub-module natural: cordic_vector_step (combinational single micro-rotation, parameterised by width); top holds FSM, counter, registers.

## Test plan
- SIN=1000, COS=0 -> PHASE=0x0000 ±2, MAGNITUDE 1647 ±2, PHASE_VALID 18 cycles after capture.
- SIN=0, COS=1000 -> PHASE=0x4000 ±2; then SIN=-1000, COS=0 -> PHASE=0x8000 ±2, PHASE_DELTA=+0x4000 ±4.
- SIN=0, COS=-1000 following 0x0000 -> PHASE=0xC000 ±2, PHASE_DELTA=-0x4000 (0xC000) ±4; wrap from 0xF000 to 0x1000 gives delta +0x2000.
- SIN=COS=-2^37 -> PHASE=0xA000 ±2, MAGNITUDE ≈ 2^37·1.4142·1.6468, no overflow; SIN=COS=0 -> PHASE=0, MAGNITUDE=0.
- CE toggled 50% duty -> identical results, latency doubled in clocks, exactly one PHASE_VALID per capture.
- RESET asserted at ITER step 5 -> no PHASE_VALID, outputs 0, next capture on first CE after release.
